// File: rtl/psram_user_responder.sv
// rtl/psram_user_responder.sv - block-RAM stand-in for the PSRAM controller user command interface
// Optional power-up pattern fill (w ^ 16'hA5A5) enabled by defining PSRAM_RESP_FILL_EN.
module psram_user_responder #(
  parameter int ADDR_W         = 14,
  parameter int BURST_BEATS    = 4,
  parameter int READ_LAT       = 8,
  parameter int RECOVER_CYCLES = 4,
  parameter int INIT_CYCLES    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd,
  input  logic        cmd_en,
  input  logic [20:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  data_mask,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        init_calib,
  output logic        busy,
  output logic        cmd_err
);
  localparam int IW     = ADDR_W - 1;
  localparam int BANK_D = 1 << IW;

`ifdef PSRAM_RESP_FILL_EN
  typedef enum logic [2:0] {S_INIT, S_FILL, S_IDLE, S_WR_BURST, S_RD_WAIT, S_RD_BURST, S_RECOVER} state_t;
`else
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR_BURST, S_RD_WAIT, S_RD_BURST, S_RECOVER} state_t;
`endif

  state_t            state, state_n, after_burst;
  logic [31:0]       cnt, cnt_n, beat, beat_n;
  logic [ADDR_W-1:0] a_reg, a_n, base, w0, w1;
  logic              wr_beat, rd_beat, fill_we, hi_even;
  logic [IW-1:0]     ev_idx, od_idx;
  logic [15:0]       ev_wd, od_wd;
  logic [1:0]        ev_be, od_be;
  logic [15:0]       mem_ev [BANK_D];
  logic [15:0]       mem_od [BANK_D];
  logic              unused_addr;

  assign unused_addr = ^addr[20:ADDR_W];
  assign after_burst = (RECOVER_CYCLES > 0) ? S_RECOVER : S_IDLE;
  assign busy = (state == S_WR_BURST) || (state == S_RD_WAIT) ||
                (state == S_RD_BURST) || (state == S_RECOVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat_n  = beat;
    a_n     = a_reg;
    wr_beat = 1'b0;
    rd_beat = 1'b0;
    fill_we = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt + 32'd1 >= 32'(INIT_CYCLES)) begin
          cnt_n = '0;
`ifdef PSRAM_RESP_FILL_EN
          state_n = S_FILL;
`else
          state_n = S_IDLE;
`endif
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
`ifdef PSRAM_RESP_FILL_EN
      S_FILL: begin
        fill_we = 1'b1;
        if (cnt == 32'(BANK_D - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
`endif
      S_IDLE: begin
        if (cmd_en) begin
          a_n   = addr[ADDR_W-1:0];
          cnt_n = '0;
          if (cmd) begin
            wr_beat = 1'b1;
            beat_n  = 32'd1;
            state_n = (BURST_BEATS > 1) ? S_WR_BURST : after_burst;
          end else begin
            state_n = S_RD_WAIT;
          end
        end
      end
      S_WR_BURST: begin
        wr_beat = 1'b1;
        beat_n  = beat + 32'd1;
        if (beat == 32'(BURST_BEATS - 1)) state_n = after_burst;
      end
      // Leaving on cycle READ_LAT-1 puts beat 0's bank addresses out one cycle before valid.
      S_RD_WAIT: begin
        if (cnt == 32'(READ_LAT - 2)) begin
          cnt_n   = '0;
          beat_n  = '0;
          state_n = S_RD_BURST;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_RD_BURST: begin
        rd_beat = 1'b1;
        beat_n  = beat + 32'd1;
        if (beat == 32'(BURST_BEATS - 1)) state_n = after_burst;
      end
      S_RECOVER: begin
        if (cnt == 32'(RECOVER_CYCLES - 1)) state_n = S_IDLE;
        else                                cnt_n   = cnt + 32'd1;
      end
      default: state_n = S_INIT;
    endcase
  end

  // Beat k covers words A+2k (upper half) and A+2k+1; they always land in opposite banks.
  always_comb begin
    base    = (state == S_IDLE) ? addr[ADDR_W-1:0] : a_reg;
    w0      = base + ((state == S_IDLE) ? '0 : ADDR_W'(beat << 1));
    w1      = w0 + ADDR_W'(1);
    hi_even = ~w0[0];
    ev_idx  = hi_even ? w0[ADDR_W-1:1] : w1[ADDR_W-1:1];
    od_idx  = hi_even ? w1[ADDR_W-1:1] : w0[ADDR_W-1:1];
    ev_wd   = hi_even ? wr_data[31:16] : wr_data[15:0];
    od_wd   = hi_even ? wr_data[15:0]  : wr_data[31:16];
    ev_be   = hi_even ? ~data_mask[3:2] : ~data_mask[1:0];
    od_be   = hi_even ? ~data_mask[1:0] : ~data_mask[3:2];
`ifdef PSRAM_RESP_FILL_EN
    if (fill_we) begin
      ev_idx = cnt[IW-1:0];
      od_idx = cnt[IW-1:0];
      ev_wd  = 16'({cnt[IW-1:0], 1'b0}) ^ 16'hA5A5;
      od_wd  = 16'({cnt[IW-1:0], 1'b1}) ^ 16'hA5A5;
      ev_be  = 2'b11;
      od_be  = 2'b11;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_beat || fill_we) begin
      if (ev_be[1]) mem_ev[ev_idx][15:8] <= ev_wd[15:8];
      if (ev_be[0]) mem_ev[ev_idx][7:0]  <= ev_wd[7:0];
      if (od_be[1]) mem_od[od_idx][15:8] <= od_wd[15:8];
      if (od_be[0]) mem_od[od_idx][7:0]  <= od_wd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      beat          <= '0;
      a_reg         <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      init_calib    <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      beat          <= beat_n;
      a_reg         <= a_n;
      rd_data_valid <= rd_beat;
      if (rd_beat)
        rd_data <= hi_even ? {mem_ev[ev_idx], mem_od[od_idx]} : {mem_od[od_idx], mem_ev[ev_idx]};
      if (state_n == S_IDLE) init_calib <= 1'b1;
      if (cmd_en && (state != S_IDLE)) cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psram_user_responder.sv
// tb/tb_psram_user_responder.sv - randomized self-checking bench for psram_user_responder
module tb_psram_user_responder;
  localparam int AW = 14;
  localparam int N  = 1 << AW;
  localparam int BB = 4;
  localparam int RL = 8;
  localparam int RC = 4;
  localparam int IC = 64;

  logic        clk = 1'b0;
  logic        rst_n, cmd, cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic [31:0] rd_data;
  logic        rd_data_valid, init_calib, busy, cmd_err;

  int total  = 0;
  int bad    = 0;
  int vcount = 0;
  int exp_v  = 0;

  logic [15:0] mdl [N];
  logic [1:0]  kn  [N];

  psram_user_responder #(
    .ADDR_W(AW), .BURST_BEATS(BB), .READ_LAT(RL), .RECOVER_CYCLES(RC), .INIT_CYCLES(IC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rd_data_valid) vcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_write(input int a, input logic [127:0] d, input logic [15:0] m);
    for (int k = 0; k < BB; k++) begin
      for (int h = 0; h < 2; h++) begin
        int w;
        logic [15:0] dw;
        logic [1:0]  mm;
        w  = (a + 2 * k + h) % N;
        dw = (h == 0) ? d[32*k+16 +: 16] : d[32*k +: 16];
        mm = (h == 0) ? m[4*k+2 +: 2] : m[4*k +: 2];
        if (!mm[1]) begin mdl[w][15:8] = dw[15:8]; kn[w][1] = 1'b1; end
        if (!mm[0]) begin mdl[w][7:0]  = dw[7:0];  kn[w][0] = 1'b1; end
      end
    end
  endtask

  function automatic void exp_beat(input int a, input int k, output logic [31:0] e,
                                   output logic [31:0] km);
    int w0, w1;
    w0 = (a + 2 * k) % N;
    w1 = (a + 2 * k + 1) % N;
    e  = {mdl[w0], mdl[w1]};
    km = {{8{kn[w0][1]}}, {8{kn[w0][0]}}, {8{kn[w1][1]}}, {8{kn[w1][0]}}};
  endfunction

  task automatic do_init(input bit viol);
    rst_n = 1'b1;
    for (int e = 1; e <= IC; e++) begin
      if (viol && e == 10) begin
        cmd = 1'b1; cmd_en = 1'b1; addr = 21'h100; wr_data = 32'h5555_5555; data_mask = 4'h0;
      end
      @(posedge clk); @(negedge clk); cmd_en = 1'b0;
      check("init_calib", 32'(init_calib), 32'(e >= IC));
      if (viol && (e == 9 || e == 10)) check("err_init", 32'(cmd_err), 32'(e == 10));
    end
  endtask

  task automatic wait_recover(input bit viol);
    repeat (RC - 1) begin @(posedge clk); @(negedge clk); end
    check("rec_busy", 32'(busy), 32'd1);
    if (viol) begin cmd = 1'b0; cmd_en = 1'b1; addr = 21'h200; end
    @(posedge clk); @(negedge clk); cmd_en = 1'b0;
    check("rec_idle", 32'(busy), 32'd0);
    if (viol) check("err_recover", 32'(cmd_err), 32'd1);
  endtask

  task automatic do_write(input int a, input logic [127:0] d, input logic [15:0] m);
    cmd = 1'b1; cmd_en = 1'b1; addr = {7'($urandom), 14'(a)};
    for (int k = 0; k < BB; k++) begin
      wr_data   = d[32*k +: 32];
      data_mask = m[4*k +: 4];
      @(posedge clk); @(negedge clk); cmd_en = 1'b0;
      if (k == 0) check("wr_busy", 32'(busy), 32'd1);
    end
    mdl_write(a, d, m);
    wait_recover(1'b0);
  endtask

  task automatic do_read(input int a, input int viol_e, input int rst_beat, input bit rec_viol,
                         output logic [31:0] first);
    logic [31:0] e, km;
    first = '0;
    cmd = 1'b0; cmd_en = 1'b1; addr = {7'($urandom), 14'(a)};
    @(posedge clk); @(negedge clk); cmd_en = 1'b0;
    check("rd_busy", 32'(busy), 32'd1);
    for (int ed = 1; ed < RL + BB; ed++) begin
      if (ed == viol_e) begin
        cmd = 1'b1; cmd_en = 1'b1; addr = 21'h100; wr_data = 32'hDEAD_BEEF; data_mask = 4'h0;
      end
      @(posedge clk); @(negedge clk); cmd_en = 1'b0;
      check("rd_valid", 32'(rd_data_valid), 32'(ed >= RL));
      if (ed == viol_e) check("err_rdburst", 32'(cmd_err), 32'd1);
      if (ed >= RL) begin
        exp_beat(a, ed - RL, e, km);
        check("rd_data", rd_data & km, e & km);
        if (ed == RL) first = rd_data;
        if (ed - RL == rst_beat) begin
          #2 rst_n = 1'b0;
          #1 check("rst_valid", 32'(rd_data_valid), 32'd0);
          exp_v += rst_beat + 1;
          return;
        end
      end
    end
    exp_v += BB;
    wait_recover(rec_viol);
  endtask

  task automatic check_reset_vals();
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_valid0", 32'(rd_data_valid), 32'd0);
    check("rst_calib", 32'(init_calib), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
  endtask

  initial begin
    logic [31:0]  f;
    logic [127:0] d;
    logic [15:0]  m;
    int a, b;
    rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = 4'hF;
    for (int i = 0; i < N; i++) kn[i] = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    do_init(1'b0);

    do_write(32'h100, {96'h0, 32'h1234_5678}, {12'hFFF, 4'b0011});
    do_read(32'h100, 0, -1, 1'b0, f);
    check("word_w100", {16'h0, f[31:16]}, 32'h1234);

    do_write(32'h100, {96'h0, 32'hAB00_0000}, {12'hFFF, 4'b0111});
    do_read(32'h100, 0, -1, 1'b0, f);
    check("lane_hi", {16'h0, f[31:16]}, 32'hAB34);
    do_write(32'h100, {96'h0, 32'h00CD_0000}, {12'hFFF, 4'b1011});
    do_read(32'h100, 0, -1, 1'b0, f);
    check("lane_lo", {16'h0, f[31:16]}, 32'hABCD);

    do_write(32'h3FFF, {96'h0, 32'h1111_2222}, {12'hFFF, 4'h0});
    do_read(32'h3FFF, 0, -1, 1'b0, f);
    check("wrap_beat0", f, 32'h1111_2222);
    check("err_clean", 32'(cmd_err), 32'd0);

    for (int it = 0; it < 6; it++) begin
      a = $urandom_range(32'h200, 32'h3000);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_write(a, d, 16'h0000);
      b = a + $urandom_range(0, 3);
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom);
      do_write(b, d, m);
      do_read(a, 0, -1, 1'b0, f);
      do_read(b, 0, -1, 1'b0, f);
    end

    do_read(32'h100, RL + 1, -1, 1'b1, f);
    do_read(32'h100, 0, -1, 1'b0, f);
    check("viol_mem", {16'h0, f[31:16]}, 32'hABCD);

    do_read(32'h100, 0, 2, 1'b0, f);
    @(negedge clk);
    check_reset_vals();
    do_init(1'b1);
    do_read(32'h100, 0, -1, 1'b0, f);
    check("keep_mem", {16'h0, f[31:16]}, 32'hABCD);
    check("err_sticky", 32'(cmd_err), 32'd1);

    repeat (4) @(negedge clk);
    check("valid_pulses", 32'(vcount), 32'(exp_v));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_user_responder.md
Name: psram_user_responder

Overview:
- Cycle-level responder for the PSRAM controller user-side command interface (cmd/cmd_en/addr/wr_data/data_mask in; rd_data/rd_data_valid/init_calib out).
- Backed by on-chip block RAM. Stands in for the PSRAM controller IP on boards without PSRAM, and serves as the bench model for the DCJ11 RAM front-end.
- Latency, burst length and recovery are parameters, so the initiator's cycle counts can be checked against them.

Parameters:
- ADDR_W, 14: word-address bits implemented (2^ADDR_W 16-bit words); upper addr bits are ignored.
- BURST_BEATS, 4: 32-bit beats per command, read and write; minimum 1.
- READ_LAT, 8: cycles from cmd_en sample to first rd_data_valid; minimum 2.
- RECOVER_CYCLES, 4: idle cycles after a burst before the next command is accepted; minimum 0.
- INIT_CYCLES, 64: cycles after reset release before init_calib rises.

Ports:
- clk, input, 1: single clock; all logic is on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- cmd, input, 1: 0 = READ, 1 = WRITE; sampled with cmd_en.
- cmd_en, input, 1: single-cycle command strobe.
- addr, input, 21: 16-bit word address.
- wr_data, input, 32: write beat data.
- data_mask, input, 4: byte mask, 1 = byte not written; bit3 covers [31:24], bit0 covers [7:0].
- rd_data, output, 32: read beat data.
- rd_data_valid, output, 1: read beat qualifier.
- init_calib, output, 1: ready indication.
- busy, output, 1: command in progress or recovering.
- cmd_err, output, 1: sticky protocol-violation flag.

Behaviour:
- Reset values: rd_data 0, rd_data_valid 0, init_calib 0, busy 0, cmd_err 0; state INIT, init counter 0.
- Reset mid-operation aborts any burst and returns to INIT. Memory contents are retained, except when the Optional Feature is compiled in.
- Beat-to-address mapping, with A = addr mod 2^ADDR_W:
  - Beat k [31:16] maps to word (A+2k) mod 2^ADDR_W.
  - Beat k [15:0] maps to word (A+2k+1) mod 2^ADDR_W.
  - In each 16-bit word, [15:8] is the high byte and [7:0] the low byte. Example: mask 4'b1011 writes only the low byte of word A+2k, from wr_data[23:16].
  - Addresses wrap at 2^ADDR_W.
- Storage: two 16-bit banks, selected by word-address LSB (even and odd). The two words of a beat always fall in opposite banks, so each bank does one access per cycle. Odd A is legal.
- State INIT:
  - Counts INIT_CYCLES, then sets init_calib = 1 (stays high until reset) and moves to IDLE.
  - cmd_en in INIT is ignored and sets cmd_err.
- State IDLE (busy = 0):
  - cmd_en with cmd = 1: cycle 0 writes beat 0 (wr_data, data_mask). Go to WR_BURST if BURST_BEATS > 1, else RECOVER.
  - cmd_en with cmd = 0: latch A, go to RD_WAIT.
  - busy = 1 from the cycle after acceptance until the return to IDLE.
- State WR_BURST:
  - Samples wr_data and data_mask on cycles 1 to BURST_BEATS-1 as beats 1 to BURST_BEATS-1.
  - The initiator holds data for beats it does not update; the data_mask it drives defines which bytes are written.
  - Then go to RECOVER.
- State RD_WAIT:
  - Bank addresses for beat 0 are issued on cycle READ_LAT-1.
  - Go to RD_BURST.
- State RD_BURST:
  - rd_data_valid = 1 on cycles READ_LAT to READ_LAT+BURST_BEATS-1, contiguous.
  - rd_data = {word(A+2k), word(A+2k+1)}. rd_data holds its last value when not valid.
  - Then go to RECOVER.
- State RECOVER: RECOVER_CYCLES cycles, then IDLE. If RECOVER_CYCLES = 0, go straight to IDLE.
- cmd_en while busy: ignored (no memory effect, no extra reads) and cmd_err set. cmd_err clears only on reset.
- Read-after-write: a read accepted after the write's RECOVER returns the written data. No bypass path is needed.

Optional Feature:
- Macro: PSRAM_RESP_FILL_EN.
- Defined: after the INIT_CYCLES count, a FILL state writes every word w with the value (w xor 16'hA5A5), one word per bank per cycle. init_calib rises in the cycle after the last fill write, adding 2^(ADDR_W-1) cycles. The fill restarts on every reset.
- Undefined: no FILL state, memory content after configuration is undefined (X in simulation), and init_calib rises after exactly INIT_CYCLES.

Test Plan:
- Reset release: init_calib = 0 for INIT_CYCLES (64) cycles, then 1; with PSRAM_RESP_FILL_EN, a read of word 0x0003 returns 16'hA5A6.
- Word write then read: WRITE A = 0x0100, beat0 = 32'h1234_xxxx, mask 4'b0011; after RECOVER, READ A = 0x0100 -> rd_data_valid high on cycles 8 to 11, first beat [31:16] = 16'h1234.
- Byte lanes: write 16'h1234 to word 0x0100, then WRITE mask 4'b0111 with wr_data[31:24] = 8'hAB -> word 0x0100 reads 16'hAB34; mask 4'b1011 with [23:16] = 8'hCD -> reads 16'hABCD.
- Wrap and odd address: WRITE A = 0x3FFF (ADDR_W = 14), beat0 = 32'h1111_2222 -> word 0x3FFF = 16'h1111, word 0x0000 = 16'h2222; the read back matches.
- Protocol violations: cmd_en during INIT, during RD_BURST, and on the last RECOVER cycle -> memory unchanged, no extra rd_data_valid pulses, cmd_err = 1 until reset.
- Reset mid-burst: assert rst_n low during RD_BURST beat 2 -> rd_data_valid drops immediately; init re-runs; previously written data is intact (feature off).
